lutram_mport_ctrl: RTL and testbench
====================================

// Module: lutram_mport_ctrl
// PURPOSE
//  Parametrised multi-read-port distributed (LUT) RAM with a hardware clear sequencer.
//  Provides one synchronous write port and NRD independent read ports.
//  Each read port is either asynchronous or registered.
//  Used wherever several consumers read a small table that must be re-initialised at run time
//  (register files, lookup/context tables). Generalises the fixed 64x8 primitive in depth,
//  width, read-port count and read mode.
// PARAMETERS
//  DEPTH     64    words; power of 2, 32..256
//  WIDTH     8     bits per word, 1..64
//  NRD       3     number of read ports, 1..8
//  RD_REG    0     0: asynchronous read; 1: registered read (1-cycle latency, write-first bypass)
//  INIT_VAL  0     WIDTH-bit value written to every word by the clear sweep
// PORTS (AW = clog2(DEPTH))
//  WCLK    in   1          single clock, all state on rising edge
//  RST_N   in   1          asynchronous, active-low reset
//  CLR     in   1          pulse: start (or restart) a clear sweep
//  BUSY    out  1          1 while the clear sweep runs
//  WE      in   1          write enable
//  WADDR   in   AW         write address
//  WDATA   in   WIDTH      write data
//  PINJ    in   1          invert the stored parity bit on this write (parity build only)
//  WDROP   out  1          1-cycle pulse: a WE was discarded
//  RADDR   in   NRD*AW     read addresses; port k = [k*AW +: AW]
//  RDATA   out  NRD*WIDTH  read data; port k = [k*WIDTH +: WIDTH]
//  PERR    out  NRD        per-port parity error, aligned with RDATA
// BEHAVIOUR
//  - FSM has two states, IDLE and CLEAR. Reset state is CLEAR with sweep counter 0.
//    Every reset release therefore initialises the whole array.
//  - CLEAR: each cycle writes INIT_VAL to word[cnt] and increments cnt.
//    After cnt==DEPTH-1 is written, the FSM goes to IDLE.
//    A sweep takes exactly DEPTH cycles. BUSY = (state==CLEAR).
//  - IDLE with CLR=1: go to CLEAR, cnt=0; BUSY rises the next cycle.
//    CLR during CLEAR restarts the sweep at cnt=0.
//  - WE is honoured only when BUSY=0 and CLR=0.
//    Otherwise the write is discarded and WDROP=1 for the next cycle.
//    When CLR and WE coincide, CLR wins.
//  - Write: on a rising edge with WE accepted, word[WADDR] <= WDATA.
//  - RD_REG=0: RDATA_k = word[RADDR_k] combinationally.
//    A write becomes visible immediately after the edge.
//  - RD_REG=1: RDATA_k registers word[RADDR_k] (1-cycle latency).
//    If an accepted write targets RADDR_k in the same cycle, RDATA_k gets WDATA (write-first).
//    A clear-sweep write to RADDR_k likewise returns INIT_VAL.
//  - Reads during BUSY are legal; they return whatever mix of old and cleared words exists.
//  - Reset values: BUSY=1, WDROP=0, PERR=0, RDATA registers=0 when RD_REG=1.
//    The array itself has no reset; its contents are defined only once the sweep completes.
//  - Reset asserted mid-sweep or mid-write: the FSM returns to CLEAR, cnt=0;
//    the in-flight write is not guaranteed.
//  - Address width is exact, so no range checks are needed. cnt is AW+1 bits wide to detect the end.
// CONFIGURATION
//  - Macro LUTRAM_MPORT_PARITY_EN defined: each word stores one extra even-parity bit.
//    The stored bit is ^WDATA (^INIT_VAL for sweep writes), XORed with PINJ on user writes.
//    PERR_k = parity mismatch on the word presented at RDATA_k, with the same latency as RDATA_k.
//  - Macro not defined: no parity storage, PERR tied to 0, PINJ ignored.
// STRUCTURE
//  - Package lutram_pkg: clog2 function; FSM state typedef {ST_IDLE, ST_CLEAR};
//    parity function; localparam AW.
//  - Sub-module lutram_rd_port holds one read port: async mux, optional output register,
//    write-first bypass and parity check. It is instantiated NRD times in a generate loop.
//  - The top level holds the array, the write/clear arbitration and the FSM.
// TESTING (DEPTH=64, WIDTH=8, NRD=3 unless noted)
//  1. Release RST_N; BUSY=1 for exactly 64 cycles.
//     Then read all 64 addresses on all ports -> INIT_VAL (test with 8'hA5).
//  2. RD_REG=0: write 8'h3C to addr 5, addr 63 to 8'hC3 back-to-back; RADDR=5/63/0.
//     Expect 3C/C3/INIT right after each edge.
//  3. RD_REG=1: same cycle WE to addr 9 with 8'h77 and RADDR_1=9 -> next cycle RDATA_1=77 (bypass).
//     Port 0 on addr 9 one cycle earlier -> old value.
//  4. CLR and WE in the same cycle, then WE while BUSY -> WDROP pulses twice, target word unchanged.
//     CLR at cnt=30 restarts the sweep -> BUSY lasts 64 cycles from the restart.
//  5. RST_N pulsed at cnt=20 -> BUSY stays 1, and a full 64-cycle sweep follows release.
//     All outputs hold their reset values during reset.
//  6. With LUTRAM_MPORT_PARITY_EN: write 8'h01 with PINJ=1 to addr 2 -> PERR on a port reading addr 2.
//     Rewrite with PINJ=0 -> PERR=0. Without the macro, PERR is always 0.

Source files
------------

// File: rtl/lutram_pkg.sv
// Shared types and helpers for the multi-read-port LUT RAM and its read ports.
package lutram_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  // Even parity over a zero-extended word.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

  localparam int DEF_DEPTH = 64;
  localparam int AW = clog2(DEF_DEPTH);

endpackage

// File: rtl/lutram_rd_port.sv
// One read port of the LUT RAM: async mux, optional output register with
// write-first bypass, and parity check on the word presented at rdata.
module lutram_rd_port
  import lutram_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 8,
  parameter int MW     = 8,
  parameter int AWID   = AW,
  parameter int RD_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MW-1:0]     mem [DEPTH],
  input  logic [AWID-1:0]   raddr,
  input  logic              wr_en,
  input  logic [AWID-1:0]   wr_addr,
  input  logic [MW-1:0]     wr_word,
  output logic [WIDTH-1:0]  rdata,
  output logic              perr
);

  logic [MW-1:0] rd_word;
  logic [MW-1:0] word_d;
  logic [MW-1:0] word_q;
  logic [MW-1:0] word_out;

  // The register captures the post-edge contents, so a same-cycle write wins.
  always_comb begin
    rd_word  = mem[raddr];
    word_d   = (wr_en && (wr_addr == raddr)) ? wr_word : rd_word;
    word_out = (RD_REG != 0) ? word_q : rd_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign rdata = word_out[WIDTH-1:0];

`ifdef LUTRAM_MPORT_PARITY_EN
  assign perr = ^word_out;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: rtl/lutram_mport_ctrl.sv
// Multi-read-port LUT RAM with a hardware clear sweep; optional per-word parity
// is enabled by defining LUTRAM_MPORT_PARITY_EN.
module lutram_mport_ctrl
  import lutram_pkg::*;
#(
  parameter int              DEPTH    = 64,
  parameter int              WIDTH    = 8,
  parameter int              NRD      = 3,
  parameter int              RD_REG   = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int             LAW      = clog2(DEPTH)
) (
  input  logic                 WCLK,
  input  logic                 RST_N,
  input  logic                 CLR,
  output logic                 BUSY,
  input  logic                 WE,
  input  logic [LAW-1:0]       WADDR,
  input  logic [WIDTH-1:0]     WDATA,
  input  logic                 PINJ,
  output logic                 WDROP,
  input  logic [NRD*LAW-1:0]   RADDR,
  output logic [NRD*WIDTH-1:0] RDATA,
  output logic [NRD-1:0]       PERR
);

`ifdef LUTRAM_MPORT_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
  logic unused_pinj;
  assign unused_pinj = PINJ;
`endif

  state_e           state_q, state_d;
  logic [LAW:0]     cnt_q, cnt_d;
  logic             wdrop_q, wdrop_d;
  logic             we_ok;
  logic             wr_en;
  logic [LAW-1:0]   wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [MW-1:0]    wr_word;
  logic [MW-1:0]    mem_q [DEPTH];

  // CLR always wins: it restarts the sweep from word 0 in either state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (CLR) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + (LAW+1)'(1);
      if (cnt_q == (LAW+1)'(DEPTH - 1)) state_d = ST_IDLE;
    end
  end

  always_comb begin
    we_ok   = WE && (state_q == ST_IDLE) && !CLR;
    wdrop_d = WE && !we_ok;
    wr_en   = we_ok || (state_q == ST_CLEAR);
    wr_addr = (state_q == ST_CLEAR) ? cnt_q[LAW-1:0] : WADDR;
    wr_data = (state_q == ST_CLEAR) ? INIT_VAL : WDATA;
`ifdef LUTRAM_MPORT_PARITY_EN
    wr_word = {even_par(64'(wr_data)) ^ (PINJ && (state_q == ST_IDLE)), wr_data};
`else
    wr_word = wr_data;
`endif
  end

  always_ff @(posedge WCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      wdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdrop_q <= wdrop_d;
    end
  end

  // The array is deliberately unreset; the sweep defines its contents.
  always_ff @(posedge WCLK) begin
    if (wr_en) mem_q[wr_addr] <= wr_word;
  end

  assign BUSY  = (state_q == ST_CLEAR);
  assign WDROP = wdrop_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    lutram_rd_port #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .MW    (MW),
      .AWID  (LAW),
      .RD_REG(RD_REG)
    ) u_rd (
      .clk    (WCLK),
      .rst_n  (RST_N),
      .mem    (mem_q),
      .raddr  (RADDR[k*LAW +: LAW]),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_word(wr_word),
      .rdata  (RDATA[k*WIDTH +: WIDTH]),
      .perr   (PERR[k])
    );
  end

endmodule

// File: tb/tb_lutram_mport_ctrl.sv
// Scoreboard bench for lutram_mport_ctrl: one async and one registered-read instance
// share stimulus and are compared against a word-level reference model.
module tb_lutram_mport_ctrl;
  import lutram_pkg::*;

  localparam int DEPTH = 64;
  localparam int WIDTH = 8;
  localparam int NRD   = 3;
  localparam int TAW   = AW;
  localparam logic [WIDTH-1:0] INIT = 8'hA5;

`ifdef LUTRAM_MPORT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT signals ----------------
  logic                 WCLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 CLR = 1'b0;
  logic                 WE = 1'b0;
  logic                 PINJ = 1'b0;
  logic [TAW-1:0]       WADDR = '0;
  logic [WIDTH-1:0]     WDATA = '0;
  logic [NRD*TAW-1:0]   RADDR = '0;
  logic                 busy0, busy1, wdrop0, wdrop1;
  logic [NRD*WIDTH-1:0] rdata0, rdata1;
  logic [NRD-1:0]       perr0, perr1;

  always #5 WCLK = ~WCLK;

  lutram_mport_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NRD(NRD), .RD_REG(0), .INIT_VAL(INIT)
  ) dut0 (
    .WCLK(WCLK), .RST_N(RST_N), .CLR(CLR), .BUSY(busy0), .WE(WE), .WADDR(WADDR),
    .WDATA(WDATA), .PINJ(PINJ), .WDROP(wdrop0), .RADDR(RADDR), .RDATA(rdata0), .PERR(perr0)
  );

  lutram_mport_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NRD(NRD), .RD_REG(1), .INIT_VAL(INIT)
  ) dut1 (
    .WCLK(WCLK), .RST_N(RST_N), .CLR(CLR), .BUSY(busy1), .WE(WE), .WADDR(WADDR),
    .WDATA(WDATA), .PINJ(PINJ), .WDROP(wdrop1), .RADDR(RADDR), .RDATA(rdata1), .PERR(perr1)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] mem_m [DEPTH];
  bit               bad_m [DEPTH];
  int               left_m;
  bit               wdrop_m;
  logic [WIDTH-1:0] reg_m [NRD];
  bit               regbad_m [NRD];
  bit               reg_known;

  typedef struct packed {
    logic                 busy;
    logic                 wdrop;
    logic                 chk0;
    logic                 chk1;
    logic [NRD*WIDTH-1:0] rd0;
    logic [NRD*WIDTH-1:0] rd1;
    logic [NRD-1:0]       pe0;
    logic [NRD-1:0]       pe1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = INIT;
      bad_m[i] = 1'b0;
    end
  endtask

  task automatic reset_model();
    left_m    = DEPTH;
    wdrop_m   = 1'b0;
    reg_known = 1'b1;
    for (int k = 0; k < NRD; k++) begin
      reg_m[k]    = '0;
      regbad_m[k] = 1'b0;
    end
    clear_model();
  endtask

  // ---------------- driver ----------------
  // Drives one cycle's inputs, queues the outputs expected before the coming
  // edge, then advances the model across that edge.
  task automatic cycle(input bit rst_n, input bit clr, input bit we, input bit pinj,
                       input logic [TAW-1:0] waddr, input logic [WIDTH-1:0] wdata,
                       input logic [TAW-1:0] ra0, input logic [TAW-1:0] ra1,
                       input logic [TAW-1:0] ra2);
    exp_t           e;
    logic [TAW-1:0] ra [NRD];
    bit             busy_now;
    bit             acc;
    ra[0] = ra0; ra[1] = ra1; ra[2] = ra2;
    RST_N = rst_n; CLR = clr; WE = we; PINJ = pinj; WADDR = waddr; WDATA = wdata;
    for (int k = 0; k < NRD; k++) RADDR[k*TAW +: TAW] = ra[k];
    if (!rst_n) reset_model();
    busy_now = (left_m > 0);
    e = '0;
    e.busy  = busy_now;
    e.wdrop = wdrop_m;
    e.chk0  = !busy_now && rst_n;
    e.chk1  = reg_known;
    for (int k = 0; k < NRD; k++) begin
      e.rd0[k*WIDTH +: WIDTH] = mem_m[ra[k]];
      e.pe0[k]                = bad_m[ra[k]];
      e.rd1[k*WIDTH +: WIDTH] = reg_m[k];
      e.pe1[k]                = regbad_m[k];
    end
    exp_q.push_back(e);
    if (rst_n) begin
      acc     = we && !busy_now && !clr;
      wdrop_m = we && !acc;
      if (acc) begin
        mem_m[waddr] = wdata;
        bad_m[waddr] = PAR_EN && pinj;
      end
      if (clr) begin
        left_m = DEPTH;
        clear_model();
      end else if (left_m > 0) begin
        left_m--;
      end
      for (int k = 0; k < NRD; k++) begin
        reg_m[k]    = mem_m[ra[k]];
        regbad_m[k] = bad_m[ra[k]];
      end
      reg_known = (left_m == 0);
    end
    @(posedge WCLK);
    #2;
  endtask

  task automatic idle(input int n, input logic [TAW-1:0] ra0, input logic [TAW-1:0] ra1,
                      input logic [TAW-1:0] ra2);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, '0, '0, ra0, ra1, ra2);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge WCLK) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("busy_async", 64'(busy0), 64'(e.busy));
      chk("busy_reg", 64'(busy1), 64'(e.busy));
      chk("wdrop_async", 64'(wdrop0), 64'(e.wdrop));
      chk("wdrop_reg", 64'(wdrop1), 64'(e.wdrop));
      if (e.chk0) chk("rdata_async", 64'(rdata0), 64'(e.rd0));
      if (e.chk1) chk("rdata_reg", 64'(rdata1), 64'(e.rd1));
      if (e.chk0 || !PAR_EN) chk("perr_async", 64'(perr0), 64'(e.pe0));
      if (e.chk1 || !PAR_EN) chk("perr_reg", 64'(perr1), 64'(e.pe1));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [TAW-1:0]   wa, r0, r1, r2;
    logic [WIDTH-1:0] wd;
    bit               c, w, p;
    @(posedge WCLK);
    #2;
    // reset, then the power-on sweep
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 6'd1, 8'h11, 6'd0, 6'd1, 6'd2);
    idle(70, 6'd0, 6'd31, 6'd63);
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 0, 0, 0, '0, '0, 6'(i), 6'((i + 21) % DEPTH), 6'((i + 42) % DEPTH));

    // back-to-back async-visible writes
    cycle(1, 0, 1, 0, 6'd5, 8'h3C, 6'd5, 6'd63, 6'd0);
    cycle(1, 0, 1, 0, 6'd63, 8'hC3, 6'd5, 6'd63, 6'd0);
    idle(2, 6'd5, 6'd63, 6'd0);

    // write-first bypass on the registered instance
    cycle(1, 0, 0, 0, '0, '0, 6'd9, 6'd1, 6'd2);
    cycle(1, 0, 1, 0, 6'd9, 8'h77, 6'd0, 6'd9, 6'd2);
    idle(2, 6'd9, 6'd9, 6'd9);

    // CLR+WE collision, WE while busy, mid-sweep restart
    cycle(1, 1, 1, 0, 6'd5, 8'hEE, 6'd5, 6'd5, 6'd5);
    cycle(1, 0, 1, 0, 6'd5, 8'hDD, 6'd5, 6'd5, 6'd5);
    idle(29, 6'd5, 6'd5, 6'd5);
    cycle(1, 1, 0, 0, '0, '0, 6'd5, 6'd5, 6'd5);
    idle(70, 6'd5, 6'd63, 6'd9);

    // reset pulse mid-sweep
    cycle(1, 0, 1, 0, 6'd20, 8'h42, 6'd20, 6'd20, 6'd20);
    cycle(1, 1, 0, 0, '0, '0, 6'd20, 6'd20, 6'd20);
    idle(20, 6'd20, 6'd20, 6'd20);
    cycle(0, 0, 0, 0, '0, '0, 6'd20, 6'd20, 6'd20);
    cycle(0, 0, 1, 0, 6'd3, 8'h99, 6'd20, 6'd20, 6'd20);
    idle(70, 6'd20, 6'd3, 6'd0);

    // parity injection and repair
    cycle(1, 0, 1, 1, 6'd2, 8'h01, 6'd2, 6'd2, 6'd7);
    idle(2, 6'd2, 6'd2, 6'd7);
    cycle(1, 0, 1, 0, 6'd2, 8'h01, 6'd2, 6'd2, 6'd7);
    idle(2, 6'd2, 6'd2, 6'd7);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      c  = ($urandom_range(0, 79) == 0);
      w  = ($urandom_range(0, 1) == 1);
      p  = ($urandom_range(0, 7) == 0);
      wa = 6'($urandom_range(0, DEPTH - 1));
      wd = 8'($urandom_range(0, 255));
      r0 = 6'($urandom_range(0, DEPTH - 1));
      r1 = ($urandom_range(0, 1) == 1) ? wa : 6'($urandom_range(0, DEPTH - 1));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, DEPTH - 1));
      cycle(1, c, w, p, wa, wd, r0, r1, r2);
    end
    idle(3, 6'd0, 6'd1, 6'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
